// File: rtl/vic_prio_pkg.sv
// Shared constants and FSM encoding for the vic_prio vectored interrupt controller.
// The optional edge-capture build is selected with the VIC_EDGE_EN macro in vic_prio.sv.
package vic_pkg;

    localparam int unsigned N_MAX  = 16;
    localparam int unsigned VW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_HOLD
    } vic_state_e;

    // Index width, kept at least 1 bit so a single-channel build still has a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any channel is pending and
// which one wins. Purely combinational.
module vic_prio_enc
    import vic_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  pend,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend[i] && !any) begin
                any = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/vic_prio.sv
// N-channel fixed-priority vectored interrupt controller with masking and UNA reads.
// Define VIC_EDGE_EN to capture rising edges of ireq in per-channel latches; otherwise level-sensitive.
module vic_prio
    import vic_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned VW = VW_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    output logic            wb_irq_o,
    output logic [VW-1:0]   wb_dat_o,
    input  logic            wb_stb_i,
    input  logic            wb_una_i,
    output logic            wb_ack_o,
    input  logic [VW-1:0]   rsel,
    input  logic [N*VW-1:0] ivec,
    input  logic [N-1:0]    ireq,
    input  logic [N-1:0]    imask,
    output logic [N-1:0]    iack
);

    localparam int unsigned IW = idx_w(N);

    vic_state_e    state_q, state_d;
    logic          irq_q, irq_d;
    logic          ack_q, ack_d;
    logic [VW-1:0] dat_q, dat_d;
    logic [N-1:0]  iack_q, iack_d;

    logic [N-1:0]  req_eff;
    logic [N-1:0]  pend;
    logic          any;
    logic [IW-1:0] idx;

`ifdef VIC_EDGE_EN
    logic [N-1:0] edge_q, edge_d;
    logic [N-1:0] ireq_q, ireq_d;

    // A fresh rising edge wins over the iack clear so a back-to-back event is not lost.
    always_comb begin
        ireq_d = ireq;
        edge_d = (edge_q & ~iack_q) | (ireq & ~ireq_q);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            edge_q <= '0;
            ireq_q <= '0;
        end else begin
            edge_q <= edge_d;
            ireq_q <= ireq_d;
        end
    end

    assign req_eff = edge_q;
`else
    assign req_eff = ireq;
`endif

    assign pend = req_eff & imask;

    vic_prio_enc #(
        .N  (N),
        .IW (IW)
    ) u_enc (
        .pend (pend),
        .any  (any),
        .idx  (idx)
    );

    always_comb begin
        state_d = state_q;
        irq_d   = |pend;
        ack_d   = 1'b0;
        iack_d  = '0;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_stb_i) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (wb_una_i) begin
                        dat_d = rsel;
                    end else if (any) begin
                        dat_d       = ivec[32'(idx) * VW +: VW];
                        iack_d[idx] = 1'b1;
                    end else begin
                        dat_d = '0;
                    end
                end
            end
            ST_ACK: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!wb_stb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            iack_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            iack_q  <= iack_d;
        end
    end

    assign wb_irq_o = irq_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign iack     = iack_q;

endmodule

// File: tb/tb_vic_prio.sv
// Self-checking bench for vic_prio: behavioural transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vic_prio;

    localparam int N  = 3;
    localparam int VW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            irq;
    logic [VW-1:0]   dat;
    logic            stb = 1'b0;
    logic            una = 1'b0;
    logic            ack;
    logic [VW-1:0]   rsel = '0;
    logic [N*VW-1:0] ivec = '0;
    logic [N-1:0]    ireq = '0;
    logic [N-1:0]    imask = '0;
    logic [N-1:0]    iack;

    int checks = 0;
    int errors = 0;

    vic_prio #(
        .N  (N),
        .VW (VW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_irq_o   (irq),
        .wb_dat_o   (dat),
        .wb_stb_i   (stb),
        .wb_una_i   (una),
        .wb_ack_o   (ack),
        .rsel       (rsel),
        .ivec       (ivec),
        .ireq       (ireq),
        .imask      (imask),
        .iack       (iack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one grant per strobe assertion, lowest pending index wins.
    logic          m_irq, m_ack;
    logic [VW-1:0] m_dat;
    logic [N-1:0]  m_iack;
    bit            m_busy;
    logic [N-1:0]  m_lat, m_prev;
    logic [N-1:0]  m_req, m_pend;
    int            m_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_irq = 0; m_ack = 0; m_dat = '0; m_iack = '0;
            m_busy = 0; m_lat = '0; m_prev = '0;
        end else begin
            m_req = ireq;
`ifdef VIC_EDGE_EN
            m_req = m_lat;
`endif
            m_pend = m_req & imask;
            m_win = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && m_win < 0) m_win = i;
`ifdef VIC_EDGE_EN
            m_lat  = (m_lat & ~m_iack) | (ireq & ~m_prev);
            m_prev = ireq;
`endif
            m_irq = |m_pend;
            if (m_ack) begin
                m_ack = 0;
                m_iack = '0;
            end else if (m_busy) begin
                m_iack = '0;
                if (!stb) m_busy = 0;
            end else if (stb) begin
                m_busy = 1;
                m_ack = 1;
                m_iack = '0;
                if (una) m_dat = rsel;
                else if (m_win >= 0) begin
                    m_dat = ivec[m_win*VW +: VW];
                    m_iack[m_win] = 1'b1;
                end else m_dat = '0;
            end else begin
                m_iack = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_irq", 32'(irq), 32'(m_irq));
            chk("model_ack", 32'(ack), 32'(m_ack));
            chk("model_dat", 32'(dat), 32'(m_dat));
            chk("model_iack", 32'(iack), 32'(m_iack));
        end
    end

    task automatic strobe(input bit u, output logic [VW-1:0] d, output logic [N-1:0] ia);
        bit got;
        got = 0;
        d = '0;
        ia = '0;
        @(negedge clk); #1;
        stb = 1'b1;
        una = u;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                d = dat;
                ia = iack;
            end
        end
        #1;
        stb = 1'b0;
        una = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL strobe_ack_timeout actual=0 required=1");
        end
    endtask

    task automatic settle(input logic [N-1:0] rq, input logic [N-1:0] mk);
        @(negedge clk); #1;
        ireq = rq;
        imask = mk;
        repeat (2) @(negedge clk);
    endtask

    logic [VW-1:0] d;
    logic [N-1:0]  ia;
    int            n_ack, n_iack;
    bit            seen;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ivec = {16'o64, 16'o60, 16'o54};
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_iack", 32'(iack), 32'd0);

        // Reset asserted while the ACK cycle is on the outputs
        settle(3'b010, 3'b111);
        @(negedge clk); #1 stb = 1'b1;
        @(posedge clk); #1;
        chk("t1_ack_before_rst", 32'(ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_irq", 32'(irq), 32'd0);
        chk("t1_ack", 32'(ack), 32'd0);
        chk("t1_iack", 32'(iack), 32'd0);
        chk("t1_dat", 32'(dat), 32'd0);
        stb = 1'b0;
        ireq = '0;
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_no_ack_after_rst", 32'(ack), 32'd0);
            chk("t1_no_iack_after_rst", 32'(iack), 32'd0);
        end

        // Priority among pending channels
        settle(3'b000, 3'b111);
        settle(3'b110, 3'b111);
        chk("t2_irq", 32'(irq), 32'd1);
        strobe(1'b0, d, ia);
        chk("t2_dat", 32'(d), 32'o60);
        chk("t2_iack", 32'(ia), 32'b010);

        // Masked request is spurious
        settle(3'b100, 3'b011);
        chk("t3_irq", 32'(irq), 32'd0);
        strobe(1'b0, d, ia);
        chk("t3_dat", 32'(d), 32'd0);
        chk("t3_iack", 32'(ia), 32'd0);

        // UNA read returns rsel without a grant
        rsel = 16'o177;
        settle(3'b001, 3'b111);
        strobe(1'b1, d, ia);
        chk("t4_dat", 32'(d), 32'o177);
        chk("t4_iack", 32'(ia), 32'd0);

`ifdef VIC_EDGE_EN
        settle(3'b000, 3'b111);
        for (int k = 0; k < 5; k++) begin
            strobe(1'b0, d, ia);
            if (ia == '0) break;
        end
        @(negedge clk); #1 ireq = 3'b100;
        @(negedge clk); #1 ireq = 3'b000;
        repeat (2) @(negedge clk);
        chk("t5_irq", 32'(irq), 32'd1);
        strobe(1'b0, d, ia);
        chk("t5_dat", 32'(d), 32'o64);
        chk("t5_iack", 32'(ia), 32'b100);
        strobe(1'b0, d, ia);
        chk("t5_spurious_dat", 32'(d), 32'd0);
        chk("t5_spurious_iack", 32'(ia), 32'd0);
`endif

        // Strobe held for several cycles yields exactly one grant
        settle(3'b000, 3'b111);
        settle(3'b001, 3'b111);
        @(negedge clk); #1 stb = 1'b1;
        n_ack = 0;
        n_iack = 0;
        repeat (5) begin
            @(negedge clk);
            n_ack += int'(ack);
            n_iack += int'($countones(iack));
        end
        #1 stb = 1'b0;
        chk("t6_ack_count", 32'(n_ack), 32'd1);
        chk("t6_iack_count", 32'(n_iack), 32'd1);
        repeat (2) @(negedge clk);
        #1 stb = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        #1 stb = 1'b0;
        chk("t6_reack", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            if (c % 20 == 0) ivec = {16'($urandom), 16'($urandom), 16'($urandom)};
            ireq  = N'($urandom);
            imask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            rsel  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) stb = ~stb;
            una   = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #1 stb = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
